// File: rtl/calc_entry_if.sv
// calc_entry_if -- keypad / ALU / display bundle for the calculator entry block.
//   key_valid, key_code   : keypad strobe and 4-bit key code (into the block)
//   key_ready             : block can accept a key this cycle
//   num1_bcd, num2_bcd    : 4-digit BCD operands to the ALU
//   operation             : ALU op, 01 '+', 10 '-', 00 none
//   result_bcd            : combinational ALU result (into the block)
//   display_bcd           : value to show
//   result_valid          : one-cycle pulse when a new result is registered
// Modports: slave = calc_entry side, master = keypad/ALU/display side.
interface calc_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] num1_bcd;
    logic [15:0] num2_bcd;
    logic [1:0]  operation;
    logic [15:0] result_bcd;
    logic [15:0] display_bcd;
    logic        result_valid;

    modport slave (
        input  key_valid, key_code, result_bcd,
        output key_ready, num1_bcd, num2_bcd, operation, display_bcd, result_valid
    );
    modport master (
        output key_valid, key_code, result_bcd,
        input  key_ready, num1_bcd, num2_bcd, operation, display_bcd, result_valid
    );
endinterface

// File: rtl/calc_entry.sv
// calc_entry -- keypad entry state machine for a 4-digit BCD calculator.
// Collects two operands and an operation from keypad strobes, drives them
// to an external combinational ALU, registers the ALU result for one cycle
// in CALC and then shows it.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : calc_entry_if.slave (keypad, ALU operands/result, display)
// Optional feature: define CALC_ENTRY_BACKSPACE_EN to make key E a backspace
// in ENTER_A/ENTER_B; otherwise E is ignored like F.
module calc_entry (
    input  logic          clk,
    input  logic          rst_n,
    calc_entry_if.slave   bus
);
    localparam logic [1:0] ENTER_A = 2'd0;
    localparam logic [1:0] ENTER_B = 2'd1;
    localparam logic [1:0] CALC    = 2'd2;
    localparam logic [1:0] SHOW    = 2'd3;

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_EQ  = 4'hC;
    localparam logic [3:0] K_CLR = 4'hD;
    localparam logic [3:0] K_BS  = 4'hE;

    logic [1:0]  state_q, state_d;
    logic [15:0] num1_q, num1_d;
    logic [15:0] num2_q, num2_d;
    logic [2:0]  cnt1_q, cnt1_d;
    logic [2:0]  cnt2_q, cnt2_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] result_q, result_d;
    logic        rvld_q, rvld_d;

    logic        key_ready;
    logic        accept;
    logic        is_digit;
    logic        is_addsub;
    logic [1:0]  key_op;
    logic [15:0] opnd, opnd_n;
    logic [2:0]  cnt, cnt_n;

    assign key_ready = (state_q != CALC);
    assign accept    = bus.key_valid && key_ready;
    assign is_digit  = (bus.key_code <= 4'd9);
    assign is_addsub = (bus.key_code == K_ADD) || (bus.key_code == K_SUB);
    assign key_op    = (bus.key_code == K_ADD) ? 2'b01 : 2'b10;

    always_comb begin
        state_d  = state_q;
        num1_d   = num1_q;
        num2_d   = num2_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        op_d     = op_q;
        result_d = result_q;
        rvld_d   = 1'b0;

        // Operand currently being edited and its edited value.
        opnd   = (state_q == ENTER_A) ? num1_q : num2_q;
        cnt    = (state_q == ENTER_A) ? cnt1_q : cnt2_q;
        opnd_n = opnd;
        cnt_n  = cnt;

        if (state_q == CALC) begin
            result_d = bus.result_bcd;
            rvld_d   = 1'b1;
            state_d  = SHOW;
        end else if (accept && bus.key_code == K_CLR) begin
            num1_d   = 16'h0000;
            num2_d   = 16'h0000;
            cnt1_d   = 3'd0;
            cnt2_d   = 3'd0;
            op_d     = 2'b00;
            result_d = 16'h0000;
            state_d  = ENTER_A;
        end else if (accept && (state_q == ENTER_A || state_q == ENTER_B)) begin
            if (is_digit) begin
                // Full operand ignores further digits; leading zeros are dropped.
                if (cnt != 3'd4 && !(bus.key_code == 4'd0 && cnt == 3'd0)) begin
                    opnd_n = {opnd[11:0], bus.key_code};
                    cnt_n  = cnt + 3'd1;
                end
            end
`ifdef CALC_ENTRY_BACKSPACE_EN
            else if (bus.key_code == K_BS) begin
                opnd_n = {4'h0, opnd[15:4]};
                cnt_n  = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
            end
`endif
            else if (is_addsub) begin
                op_d = key_op;
                if (state_q == ENTER_A) begin
                    num2_d  = 16'h0000;
                    cnt2_d  = 3'd0;
                    state_d = ENTER_B;
                end
            end else if (bus.key_code == K_EQ && state_q == ENTER_B) begin
                state_d = CALC;
            end

            if (state_q == ENTER_A) begin
                num1_d = opnd_n;
                cnt1_d = cnt_n;
            end else begin
                num2_d = opnd_n;
                cnt2_d = cnt_n;
            end
        end else if (accept && state_q == SHOW) begin
            if (is_digit) begin
                num1_d  = {12'h000, bus.key_code};
                cnt1_d  = (bus.key_code == 4'd0) ? 3'd0 : 3'd1;
                num2_d  = 16'h0000;
                cnt2_d  = 3'd0;
                op_d    = 2'b00;
                state_d = ENTER_A;
            end else if (is_addsub) begin
                // The carried-over result is not editable, so its count is full.
                num1_d  = result_q;
                cnt1_d  = 3'd4;
                op_d    = key_op;
                num2_d  = 16'h0000;
                cnt2_d  = 3'd0;
                state_d = ENTER_B;
            end else if (bus.key_code == K_EQ) begin
                // Repeat-equals: previous result becomes the new first operand.
                num1_d  = result_q;
                cnt1_d  = 3'd4;
                state_d = CALC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ENTER_A;
            num1_q   <= 16'h0000;
            num2_q   <= 16'h0000;
            cnt1_q   <= 3'd0;
            cnt2_q   <= 3'd0;
            op_q     <= 2'b00;
            result_q <= 16'h0000;
            rvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            op_q     <= op_d;
            result_q <= result_d;
            rvld_q   <= rvld_d;
        end
    end

    always_comb begin
        case (state_q)
            ENTER_A: bus.display_bcd = num1_q;
            ENTER_B: bus.display_bcd = (cnt2_q != 3'd0) ? num2_q : num1_q;
            default: bus.display_bcd = result_q;
        endcase
    end

    assign bus.key_ready    = key_ready;
    assign bus.num1_bcd     = num1_q;
    assign bus.num2_bcd     = num2_q;
    assign bus.operation    = op_q;
    assign bus.result_valid = rvld_q;
endmodule
